// File: rtl/scalar_pkg.sv
// Shared definitions for the scalar loop sequencer: scalar-file op encodings,
// sequencer state enum and the default counter width.
package scalar_pkg;

  localparam int unsigned SCALAR_W = 32;

  localparam logic [1:0] OP_INCRI = 2'b00;
  localparam logic [1:0] OP_INCRJ = 2'b01;
  localparam logic [1:0] OP_SETN  = 2'b10;
  localparam logic [1:0] OP_READ  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SETN = 3'd1,
    S_READ = 3'd2,
    S_CAPT = 3'd3,
    S_EMIT = 3'd4,
    S_INCJ = 3'd5,
    S_INCI = 3'd6,
    S_DONE = 3'd7
  } seq_state_t;

  // READ is the only side-effect-free op, so it is the fallback for every other state.
  function automatic logic [1:0] op_for_state(input seq_state_t st);
    case (st)
      S_SETN:  op_for_state = OP_SETN;
      S_INCJ:  op_for_state = OP_INCRJ;
      S_INCI:  op_for_state = OP_INCRI;
      default: op_for_state = OP_READ;
    endcase
  endfunction

endpackage

// File: rtl/scalar_loop_seq.sv
// Drives the scalar register file through a rows x (n+1) loop and streams the
// (i, j) index pairs it reads back to the vector datapath.
module scalar_loop_seq
  import scalar_pkg::*;
#(
  parameter int W  = SCALAR_W,
  parameter int RW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [W-1:0]  cmd_n,
  input  logic [RW-1:0] cmd_rows,
  output logic [1:0]    sca_reg_op,
  output logic [W-1:0]  imm,
  input  logic [W-1:0]  i_in,
  input  logic [W-1:0]  j_in,
  input  logic [W-1:0]  n_in,
  output logic          idx_valid,
  input  logic          idx_ready,
  output logic [W-1:0]  idx_i,
  output logic [W-1:0]  idx_j,
  output logic          busy,
  output logic          done,
  output logic          sync_err
);

  seq_state_t    state_q, state_d;
  logic [RW-1:0] rows_left_q, rows_left_d;
  logic [W-1:0]  imm_q, imm_d;
  logic [W-1:0]  cap_n_q, cap_n_d;
  logic [W-1:0]  idx_i_q, idx_i_d;
  logic [W-1:0]  idx_j_q, idx_j_d;
  logic          first_q, first_d;
  logic          sync_err_q, sync_err_d;
  logic [1:0]    op_q;
  logic          valid_q, done_q, busy_q, ready_q;

  always_comb begin
    state_d     = state_q;
    rows_left_d = rows_left_q;
    imm_d       = imm_q;
    cap_n_d     = cap_n_q;
    idx_i_d     = idx_i_q;
    idx_j_d     = idx_j_q;
    first_d     = first_q;
    sync_err_d  = sync_err_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          if (cmd_rows == {RW{1'b0}}) begin
            state_d = S_DONE;
          end else begin
            state_d     = S_SETN;
            rows_left_d = cmd_rows;
            imm_d       = cmd_n;
            first_d     = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SETN: state_d = S_READ;
      S_READ: state_d = S_CAPT;
      S_CAPT: begin
        idx_i_d = i_in;
        idx_j_d = j_in;
        cap_n_d = n_in;
        // A job that does not start at j=0 is flagged but allowed to run.
        if (first_q && (j_in != {W{1'b0}})) begin
          sync_err_d = 1'b1;
        end else begin
          sync_err_d = sync_err_q;
        end
        first_d = 1'b0;
        state_d = S_EMIT;
      end
      S_EMIT: begin
        if (idx_ready) begin
          state_d = S_INCJ;
        end else begin
          state_d = S_EMIT;
        end
      end
      S_INCJ: begin
        if (idx_j_q != cap_n_q) begin
          state_d = S_READ;
        end else begin
          rows_left_d = rows_left_q - RW'(1);
          state_d     = S_INCI;
        end
      end
      S_INCI: begin
        if (rows_left_q == {RW{1'b0}}) begin
          state_d = S_DONE;
        end else begin
          state_d = S_READ;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they belong to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rows_left_q <= {RW{1'b0}};
      imm_q       <= {W{1'b0}};
      cap_n_q     <= {W{1'b0}};
      idx_i_q     <= {W{1'b0}};
      idx_j_q     <= {W{1'b0}};
      first_q     <= 1'b0;
      sync_err_q  <= 1'b0;
      op_q        <= OP_READ;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      ready_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      rows_left_q <= rows_left_d;
      imm_q       <= imm_d;
      cap_n_q     <= cap_n_d;
      idx_i_q     <= idx_i_d;
      idx_j_q     <= idx_j_d;
      first_q     <= first_d;
      sync_err_q  <= sync_err_d;
      op_q        <= op_for_state(state_d);
      valid_q     <= (state_d == S_EMIT);
      done_q      <= (state_d == S_DONE);
      busy_q      <= (state_d != S_IDLE);
      ready_q     <= (state_d == S_IDLE);
    end
  end

  assign sca_reg_op = op_q;
  assign imm        = imm_q;
  assign idx_valid  = valid_q;
  assign idx_i      = idx_i_q;
  assign idx_j      = idx_j_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign cmd_ready  = ready_q;
  assign sync_err   = sync_err_q;

endmodule
